div: RTL and testbench
======================

// Module: div
// PURPOSE
// - Multi-cycle iterative divider serving the execute stage.
// - ex drives operands, sign mode and start, and holds its stall request while waiting.
// - The divider returns {remainder, quotient} with a ready strobe, then waits for ex to drop start.
// - Radix-2 restoring algorithm, one quotient bit per clock. Handles signed and unsigned operands,
//   divide-by-zero, and cancellation (annul) from a pipeline flush.
// PARAMETERS
// - DATA_W   32   operand width; quotient and remainder are DATA_W each; result_o is 2*DATA_W.
// PORTS
// - clk            in   1         single clock; all state updates on rising edge
// - rst            in   1         asynchronous, active-low reset
// - signed_div_i   in   1         1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
// - opdata1_i      in   DATA_W    dividend; sampled with start
// - opdata2_i      in   DATA_W    divisor; sampled with start
// - start_i        in   1         request; held high by ex until ready_o seen
// - annul_i        in   1         cancel in-flight division (flush)
// - result_o       out  2*DATA_W  {remainder[63:32], quotient[31:0]}; valid while ready_o=1
// - ready_o        out  1         result valid
// BEHAVIOUR
// - Reset (rst=0, any time, incl. mid-division):
//   - state=FREE, cnt=0, ready_o=0, result_o=0.
//   - Internal dividend/divisor registers cleared.
// - State FREE:
//   - ready_o=0, result_o=0.
//   - start_i=1 && annul_i=0 && opdata2_i==0 -> BYZERO.
//   - start_i=1 && annul_i=0 && opdata2_i!=0 -> ON. Capture operands; cnt=0.
//   - Operand capture for signed mode: a negative operand is replaced by its two's complement
//     (abs value). The original operands are also latched for sign fix-up.
//   - start_i=1 with annul_i=1 -> stay FREE.
// - State BYZERO:
//   - Working dividend=0 -> END next edge.
//   - ready_o rises 2 edges after the start-sampling edge; result_o=0.
// - State ON, annul_i=0, cnt<DATA_W:
//   - Form diff = partial_rem(DATA_W+1 b) - {1'b0,divisor}.
//   - If diff is negative: shift dividend register left, inserting 0.
//   - Otherwise: replace the high part with diff and shift left, inserting 1.
//   - cnt++.
// - State ON, annul_i=0, cnt==DATA_W: sign fix-up, then -> END.
//   - Quotient is negated iff signed && dividend sign != divisor sign.
//   - Remainder is negated iff signed && dividend negative (remainder takes the dividend's sign).
// - State ON, annul_i=1 (any cnt): -> FREE next edge. No ready_o pulse; result discarded.
// - State END:
//   - ready_o=1; result_o = {rem, quot}, registered and stable.
//   - Stay in END while start_i=1.
//   - start_i=0 -> FREE; ready_o=0 and result_o=0 on that edge.
//   - annul_i in END is ignored; ex deasserts start on flush.
// - Latency (nonzero divisor): ready_o first high 34 edges after the edge sampling start
//   (1 capture + 32 iterations + 1 fix-up).
// - Back-to-back divisions:
//   - A new division needs start low for at least 1 cycle (END->FREE) before re-sampling.
//   - start held high continuously never re-launches.
// - Arithmetic:
//   - All add/sub are modulo width.
//   - Signed 0x80000000 / -1 yields quot=0x80000000, rem=0 (wraps, no trap).
//   - Operands are not re-sampled after FREE; input changes during ON/END have no effect.
// - Outputs are register-driven only; no combinational input->output paths.
// STRUCTURE
// - Shared package / defines.v:
//   - State encodings DivFree=2'b00, DivByZero=2'b01, DivOn=2'b10, DivEnd=2'b11.
//   - DivStart/DivStop, DivResultReady/DivResultNotReady.
//   - DoubleRegBus reused for result_o.
// - Single module, no sub-module. The iteration subtract is inline.
// - Counter width $clog2(DATA_W)+1 (6 bits at default).
// TESTING
// - Unsigned 100/7: start=1, signed=0.
//   -> after 34 edges ready_o=1, result_o={32'd2, 32'd14}. Stays until start=0, then ready_o=0 next edge.
// - Signed -7/2 (0xFFFFFFF9 / 0x00000002)
//   -> quot=0xFFFFFFFD, rem=0xFFFFFFFF. Signed 7/-2 -> quot=0xFFFFFFFD, rem=0x00000001.
// - Divide by zero: 0x1234 / 0
//   -> ready_o=1 exactly 2 edges after start, result_o=0. Same for signed mode.
// - Annul: start 0xFFFFFFFF/3, assert annul_i at iteration 10
//   -> FREE next edge, ready_o never rises.
//   - Then start 9/3 -> {0, 3} after 34 edges.
// - Reset mid-op: drop rst at iteration 20
//   -> ready_o=0, result_o=0 immediately (async).
//   - After release, fresh division 0xFFFFFFFF/1 -> {0, 0xFFFFFFFF}.
// - Edge values: signed 0x80000000 / 0xFFFFFFFF -> {0, 0x80000000}.
//   Unsigned 5/9 -> {5, 0}. start held 3 extra cycles in END -> result stable, no relaunch.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared state encodings and handshake constants for the iterative divider
package div_pkg;
  localparam int DIV_W = 32;
  localparam logic [1:0] DivFree   = 2'b00;
  localparam logic [1:0] DivByZero = 2'b01;
  localparam logic [1:0] DivOn     = 2'b10;
  localparam logic [1:0] DivEnd    = 2'b11;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
endpackage

// File: rtl/div.sv
// div: radix-2 restoring divider, one quotient bit per clock, signed/unsigned with annul
module div import div_pkg::*; #(
  parameter int DATA_W = DIV_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);
  localparam int CW = $clog2(DATA_W) + 1;
  logic [1:0]          r_state;
  logic [CW-1:0]       r_cnt;
  logic [2*DATA_W-1:0] r_dvd;
  logic [DATA_W-1:0]   r_dvs;
  logic                r_q_neg;
  logic                r_r_neg;
  logic [2*DATA_W-1:0] r_result;
  logic                r_ready;
  logic [DATA_W:0]     w_part;
  logic [DATA_W:0]     w_diff;
  logic [DATA_W-1:0]   w_abs1;
  logic [DATA_W-1:0]   w_abs2;
  logic [DATA_W-1:0]   w_quo;
  logic [DATA_W-1:0]   w_rem;
  // r_dvd holds {partial remainder, dividend bits still to shift in / quotient bits so far};
  // the partial remainder stays below the divisor, so one extra bit suffices for the trial subtract
  assign w_part   = r_dvd[2*DATA_W-1:DATA_W-1];
  assign w_diff   = w_part - {1'b0, r_dvs};
  assign w_abs1   = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign w_abs2   = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
  assign w_quo    = r_q_neg ? -r_dvd[DATA_W-1:0] : r_dvd[DATA_W-1:0];
  assign w_rem    = r_r_neg ? -r_dvd[2*DATA_W-1:DATA_W] : r_dvd[2*DATA_W-1:DATA_W];
  assign result_o = r_result;
  assign ready_o  = r_ready;
  // control FSM, operand capture, iteration and registered result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= DivFree;
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
      r_result <= '0;
      r_ready  <= DivResultNotReady;
    end else begin
      case (r_state)
        DivFree: begin
          if (start_i == DivStart && !annul_i) begin
            if (opdata2_i == '0) begin
              r_state <= DivByZero;
            end else begin
              r_state <= DivOn;
              r_cnt   <= '0;
              r_dvd   <= {{DATA_W{1'b0}}, w_abs1};
              r_dvs   <= w_abs2;
              r_q_neg <= signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
              r_r_neg <= signed_div_i && opdata1_i[DATA_W-1];
            end
          end
        end
        DivByZero: begin
          r_dvd    <= '0;
          r_state  <= DivEnd;
          r_ready  <= DivResultReady;
          r_result <= '0;
        end
        DivOn: begin
          if (annul_i) begin
            r_state <= DivFree;
          end else if (r_cnt == CW'(DATA_W)) begin
            r_state  <= DivEnd;
            r_ready  <= DivResultReady;
            r_result <= {w_rem, w_quo};
          end else begin
            r_dvd <= w_diff[DATA_W] ? {w_part[DATA_W-1:0], r_dvd[DATA_W-2:0], 1'b0}
                                    : {w_diff[DATA_W-1:0], r_dvd[DATA_W-2:0], 1'b1};
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          if (start_i == DivStop) begin
            r_state  <= DivFree;
            r_ready  <= DivResultNotReady;
            r_result <= '0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_div.sv
// tb_div: directed and randomized checks of the iterative divider with a result scoreboard
module tb_div;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        signed_div_i = 1'b0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic [63:0] result_o;
  logic        ready_o;
  int          vectors = 0;
  int          errs = 0;
  logic [63:0] sb_q[$];
  int          lat_q[$];
  logic [63:0] last_exp;

  div #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i), .opdata1_i(opdata1_i),
    .opdata2_i(opdata2_i), .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [63:0] exp, input int lat);
    @(negedge clk);
    opdata1_i = a;
    opdata2_i = b;
    signed_div_i = s;
    start_i = 1'b1;
    sb_q.push_back(exp);
    lat_q.push_back(lat);
  endtask

  task automatic collect(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ready_o && n < 100);
    last_exp = sb_q.pop_front();
    chk({tag, "_lat"}, 64'(n), 64'(lat_q.pop_front()));
    chk({tag, "_res"}, result_o, last_exp);
  endtask

  task automatic hold(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      opdata1_i = $urandom;
      opdata2_i = $urandom;
      signed_div_i = ~signed_div_i;
      @(posedge clk);
      #1;
      chk({tag, "_hold_rdy"}, 64'(ready_o), 64'd1);
      chk({tag, "_hold_res"}, result_o, last_exp);
    end
  endtask

  task automatic release_start(input string tag);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_rel_rdy"}, 64'(ready_o), 64'd0);
    chk({tag, "_rel_res"}, result_o, 64'd0);
  endtask

  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [63:0] exp, input int lat, input int h);
    launch(a, b, s, exp, lat);
    collect(tag);
    hold(tag, h);
    release_start(tag);
  endtask

  initial begin
    logic seen;
    logic [31:0] a;
    logic [31:0] b;
    logic s;
    #1;
    chk("reset_rdy", 64'(ready_o), 64'd0);
    chk("reset_res", result_o, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    do_div("u100_7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 34, 3);
    do_div("s_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 34, 0);
    do_div("s_7_m2", 32'd7, 32'hFFFFFFFE, 1'b1, {32'h00000001, 32'hFFFFFFFD}, 34, 0);
    do_div("u_dz", 32'h1234, 32'd0, 1'b0, 64'd0, 2, 1);
    do_div("s_dz", 32'h1234, 32'd0, 1'b1, 64'd0, 2, 0);

    // annul while start is offered in FREE: nothing launches
    @(negedge clk);
    opdata1_i = 32'd50; opdata2_i = 32'd5; signed_div_i = 1'b0;
    start_i = 1'b1; annul_i = 1'b1;
    seen = 1'b0;
    repeat (3) begin @(posedge clk); #1; seen |= ready_o; end
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;
    repeat (40) begin @(posedge clk); #1; seen |= ready_o; end
    chk("annul_free_no_rdy", 64'(seen), 64'd0);

    // annul in the middle of an iteration run
    @(negedge clk);
    opdata1_i = 32'hFFFFFFFF; opdata2_i = 32'd3; signed_div_i = 1'b0; start_i = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1; start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; seen |= ready_o; end
    chk("annul_on_no_rdy", 64'(seen), 64'd0);
    do_div("u9_3", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 34, 0);

    // asynchronous reset mid-division
    @(negedge clk);
    opdata1_i = 32'hFFFFFFFF; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_rdy", 64'(ready_o), 64'd0);
    chk("rst_mid_res", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_div("u_ff_1", 32'hFFFFFFFF, 32'd1, 1'b0, {32'd0, 32'hFFFFFFFF}, 34, 0);

    // asynchronous reset while a result is being presented
    launch(32'd200, 32'd9, 1'b0, {32'd2, 32'd22}, 34);
    collect("u200_9");
    #2 rst = 1'b0;
    #1;
    chk("rst_end_rdy", 64'(ready_o), 64'd0);
    chk("rst_end_res", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    do_div("s_min_m1", 32'h80000000, 32'hFFFFFFFF, 1'b1, {32'd0, 32'h80000000}, 34, 0);
    do_div("u5_9", 32'd5, 32'd9, 1'b0, {32'd5, 32'd0}, 34, 3);
    do_div("u_max_big", 32'hFFFFFFFF, 32'h80000001, 1'b0, {32'h7FFFFFFE, 32'd1}, 34, 0);

    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      s = 1'(i);
      if (b == 32'd0) b = 32'd1;
      if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) a = 32'h7FFFFFFF;
      do_div("rand", a, b, s, model(a, b, s), 34, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
